mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-unit constants: bus widths, function codes,
// grant index width and timeout counter width.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int GNT_W      = 2;
  localparam int TMO_W      = 8;

  typedef enum logic [1:0] {
    MF_GET_CONTENTS = 2'd0,
    MF_SET_CONTENTS = 2'd1,
    MF_GET_FIELD    = 2'd2,
    MF_SET_FIELD    = 2'd3
  } mem_func_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin selector: req_i request vector, last_i last grant;
// valid_o any request, idx_o first requester after last_i.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GNT_W-1:0] last_i,
  output logic             valid_o,
  output logic [GNT_W-1:0] idx_o
);

  logic [GNT_W-1:0] c;

  // Walk offsets from farthest to nearest so the nearest wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    c       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = GNT_W'((int'(last_i) + k) % NREQ);
      if (req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = c;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: NREQ requester ports share one memory unit.
// Ports: req_* requester side, mem_*/address*/write_data/read_data* memory side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_execute,
  input  logic [NREQ*MEM_ADDR_W-1:0] req_address1,
  input  logic [NREQ*MEM_ADDR_W-1:0] req_address2,
  input  logic [NREQ*2-1:0]          req_mem_func,
  input  logic [NREQ*MEM_DATA_W-1:0] req_write_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [MEM_DATA_W-1:0]      rsp_read_data1,
  output logic [MEM_DATA_W-1:0]      rsp_read_data2,
  output logic                       mem_execute,
  output logic [MEM_ADDR_W-1:0]      address1,
  output logic [MEM_ADDR_W-1:0]      address2,
  output logic [1:0]                 mem_func,
  output logic [MEM_DATA_W-1:0]      write_data,
  input  logic                       mem_ready,
  input  logic [MEM_DATA_W-1:0]      read_data1,
  input  logic [MEM_DATA_W-1:0]      read_data2,
  output logic [GNT_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       arb_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [GNT_W-1:0]      gnt_q, gnt_d;
  logic [GNT_W-1:0]      last_q, last_d;
  logic [MEM_ADDR_W-1:0] a1_q, a1_d;
  logic [MEM_ADDR_W-1:0] a2_q, a2_d;
  logic [1:0]            fn_q, fn_d;
  logic [MEM_DATA_W-1:0] wd_q, wd_d;
  logic [MEM_DATA_W-1:0] rd1_q, rd1_d;
  logic [MEM_DATA_W-1:0] rd2_q, rd2_d;
  logic [NREQ-1:0]       rdy_q, rdy_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      cnt_q, cnt_d;

  logic                  pick_v;
  logic [GNT_W-1:0]      pick_idx;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i  (req_execute),
    .last_i (last_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    fn_d    = fn_q;
    wd_d    = wd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    rdy_d   = '0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_v) begin
          gnt_d   = pick_idx;
          a1_d    = req_address1[int'(pick_idx)*MEM_ADDR_W +: MEM_ADDR_W];
          a2_d    = req_address2[int'(pick_idx)*MEM_ADDR_W +: MEM_ADDR_W];
          fn_d    = req_mem_func[int'(pick_idx)*2 +: 2];
          wd_d    = req_write_data[int'(pick_idx)*MEM_DATA_W +: MEM_DATA_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          rd1_d        = read_data1;
          rd2_d        = read_data2;
          rdy_d[gnt_q] = 1'b1;
          state_d      = S_DONE;
        end else if (cnt_q == '1) begin
          // Memory hung: release the requester with zero data.
          err_d        = 1'b1;
          rd1_d        = '0;
          rd2_d        = '0;
          rdy_d[gnt_q] = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= GNT_W'(NREQ - 1);
      a1_q    <= '0;
      a2_q    <= '0;
      fn_q    <= '0;
      wd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      fn_q    <= fn_d;
      wd_q    <= wd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_execute    = (state_q == S_ISSUE);
  assign busy           = (state_q != S_IDLE);
  assign address1       = a1_q;
  assign address2       = a2_q;
  assign mem_func       = fn_q;
  assign write_data     = wd_q;
  assign req_ready      = rdy_q;
  assign rsp_read_data1 = rd1_q;
  assign rsp_read_data2 = rd2_q;
  assign grant_id       = gnt_q;
  assign arb_error      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable
// memory model and a requester monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = MEM_ADDR_W;
  localparam int DW = MEM_DATA_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_execute;
  logic [N*AW-1:0] req_address1;
  logic [N*AW-1:0] req_address2;
  logic [N*2-1:0]  req_mem_func;
  logic [N*DW-1:0] req_write_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_read_data1;
  logic [DW-1:0]   rsp_read_data2;
  logic            mem_execute;
  logic [AW-1:0]   address1;
  logic [AW-1:0]   address2;
  logic [1:0]      mem_func;
  logic [DW-1:0]   write_data;
  logic            mem_ready;
  logic [DW-1:0]   read_data1;
  logic [DW-1:0]   read_data2;
  logic [1:0]      grant_id;
  logic            busy;
  logic            arb_error;

  mem_arbiter #(
    .NREQ(N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_execute   (req_execute),
    .req_address1  (req_address1),
    .req_address2  (req_address2),
    .req_mem_func  (req_mem_func),
    .req_write_data(req_write_data),
    .req_ready     (req_ready),
    .rsp_read_data1(rsp_read_data1),
    .rsp_read_data2(rsp_read_data2),
    .mem_execute   (mem_execute),
    .address1      (address1),
    .address2      (address2),
    .mem_func      (mem_func),
    .write_data    (write_data),
    .mem_ready     (mem_ready),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .grant_id      (grant_id),
    .busy          (busy),
    .arb_error     (arb_error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          cyc = 0;
  int          mem_lat = 0;
  int          mcnt = 0;
  logic [DW-1:0] md1, md2;
  bit          drop = 1'b0;
  int          exec_cnt = 0;
  int          rdy_cnt = 0;
  int          onehot_bad = 0;
  int          rdy_cyc = 0;
  int          mr_cyc = 0;
  logic [N-1:0] last_rdy;
  logic [AW-1:0] exec_a1;
  logic [1:0]  exec_fn;
  logic [1:0]  grants[$];
  int          exec_cyc[$];
  int          t0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One cycle: memory model and requester monitor run at negedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    mem_ready = 1'b0;
    if (mem_execute) begin
      exec_cnt++;
      grants.push_back(grant_id);
      exec_cyc.push_back(cyc);
      exec_a1 = address1;
      exec_fn = mem_func;
      mcnt    = mem_lat;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mem_ready  = 1'b1;
        read_data1 = md1;
        read_data2 = md2;
        mr_cyc     = cyc;
      end
    end
    if (|req_ready) begin
      rdy_cnt++;
      last_rdy = req_ready;
      rdy_cyc  = cyc;
      if (!$onehot(req_ready)) onehot_bad++;
      if (drop) req_execute = req_execute & ~req_ready;
    end
  endtask

  task automatic clr();
    exec_cnt   = 0;
    rdy_cnt    = 0;
    onehot_bad = 0;
    grants.delete();
    exec_cyc.delete();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req_execute = '0;
    mem_ready   = 1'b0;
    mcnt        = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clr();
  endtask

  task automatic wait_exec(string tag, int n, int bound);
    int t = 0;
    while (exec_cnt < n && t < bound) begin
      tick();
      t++;
    end
    chk(tag, 32'(exec_cnt >= n), 1);
  endtask

  task automatic wait_rdy(string tag, int n, int bound);
    int t = 0;
    while (rdy_cnt < n && t < bound) begin
      tick();
      t++;
    end
    chk(tag, 32'(rdy_cnt >= n), 1);
  endtask

  task automatic set_port(int p, logic [AW-1:0] a1, logic [AW-1:0] a2,
                          logic [1:0] fn, logic [DW-1:0] wd);
    req_address1[p*AW +: AW]   = a1;
    req_address2[p*AW +: AW]   = a2;
    req_mem_func[p*2 +: 2]     = fn;
    req_write_data[p*DW +: DW] = wd;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g[5];
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst            = 1'b0;
    req_execute    = '0;
    req_address1   = '0;
    req_address2   = '0;
    req_mem_func   = '0;
    req_write_data = '0;
    mem_ready      = 1'b0;
    read_data1     = '0;
    read_data2     = '0;
    md1            = '0;
    md2            = '0;
    last_rdy       = '0;

    do_reset();
    chk("rst_exec", 32'(mem_execute), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp1", 32'(rsp_read_data1), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(arb_error), 0);
    chk("rst_addr1", 32'(address1), 0);

    // Single request from port 2.
    set_port(2, 16'h0010, 16'h0020, MF_GET_CONTENTS, 16'h0000);
    md1 = 16'h00AB;
    md2 = 16'h00CD;
    mem_lat = 3;
    drop = 1'b1;
    req_execute = 4'b0100;
    t0 = cyc;
    wait_exec("t1_exec", 1, 10);
    chk("t1_lat", exec_cyc[0] - t0, 1);
    chk("t1_grant", 32'(grants[0]), 2);
    chk("t1_addr1", 32'(exec_a1), 32'h10);
    chk("t1_func", 32'(exec_fn), 32'(MF_GET_CONTENTS));
    wait_rdy("t1_rdy", 1, 20);
    chk("t1_rdyvec", 32'(last_rdy), 32'b0100);
    chk("t1_rsp1", 32'(rsp_read_data1), 32'hAB);
    chk("t1_rsp2", 32'(rsp_read_data2), 32'hCD);
    chk("t1_rdylat", rdy_cyc - mr_cyc, 1);
    tick();
    tick();
    chk("t1_nexec", exec_cnt, 1);
    chk("t1_nrdy", rdy_cnt, 1);
    chk("t1_idle", 32'(busy), 0);

    // All ports requesting continuously.
    do_reset();
    drop = 1'b0;
    mem_lat = 2;
    req_execute = 4'b1111;
    wait_exec("t2_exec", 5, 100);
    req_execute = '0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_order%0d", i), 32'(grants[i]), 32'(exp_g[i]));
    chk("t2_rdy4", rdy_cnt, 4);
    repeat (10) tick();
    chk("t2_rdy5", rdy_cnt, 5);
    chk("t2_exec5", exec_cnt, 5);
    chk("t2_onehot", onehot_bad, 0);

    // Port 1 arrives during port 0's WAIT.
    do_reset();
    drop = 1'b1;
    mem_lat = 4;
    md1 = 16'h005A;
    md2 = 16'h00A5;
    req_execute = 4'b0001;
    wait_exec("t3_exec0", 1, 10);
    tick();
    req_execute[1] = 1'b1;
    wait_exec("t3_exec1", 2, 40);
    chk("t3_grant1", 32'(grants[1]), 1);
    chk("t3_gap", exec_cyc[1] - rdy_cyc, 2);
    wait_rdy("t3_rdy1", 2, 40);
    chk("t3_rdyvec", 32'(last_rdy), 32'b0010);
    repeat (3) tick();
    chk("t3_nexec", exec_cnt, 2);

    // Spurious mem_ready while idle.
    tick();
    read_data1 = 16'h00EE;
    read_data2 = 16'h00EE;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("t4_nrdy", rdy_cnt, 2);
    chk("t4_rsp1", 32'(rsp_read_data1), 32'h5A);
    chk("t4_rsp2", 32'(rsp_read_data2), 32'hA5);
    chk("t4_busy", 32'(busy), 0);

    // Normal transaction, then a memory timeout.
    clr();
    set_port(3, 16'h0033, 16'h0044, MF_SET_CONTENTS, 16'h1234);
    md1 = 16'h0011;
    md2 = 16'h0022;
    mem_lat = 1;
    req_execute = 4'b1000;
    wait_rdy("t5_rdy0", 1, 20);
    chk("t5_rsp1", 32'(rsp_read_data1), 32'h11);
    chk("t5_err0", 32'(arb_error), 0);
    tick();
    tick();
    mem_lat = 0;
    req_execute = 4'b0010;
    wait_exec("t5_exec", 2, 10);
    chk("t5_grant", 32'(grants[1]), 1);
    wait_rdy("t5_rdy1", 2, 400);
    chk("t5_rdyvec", 32'(last_rdy), 32'b0010);
    chk("t5_err1", 32'(arb_error), 1);
    chk("t5_rsp1z", 32'(rsp_read_data1), 0);
    chk("t5_rsp2z", 32'(rsp_read_data2), 0);
    chk("t5_tmo", rdy_cyc - exec_cyc[1], 257);
    tick();
    tick();
    chk("t5_idle", 32'(busy), 0);

    // Reset while waiting on memory.
    clr();
    set_port(2, 16'h0010, 16'h0020, MF_GET_FIELD, 16'h0000);
    req_execute = 4'b0100;
    wait_exec("t6_exec", 1, 10);
    repeat (5) tick();
    chk("t6_busy1", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("t6_exec", 32'(mem_execute), 0);
    chk("t6_busy0", 32'(busy), 0);
    chk("t6_grant", 32'(grant_id), 0);
    chk("t6_err", 32'(arb_error), 0);
    chk("t6_addr1", 32'(address1), 0);
    chk("t6_func", 32'(mem_func), 0);
    tick();
    tick();
    chk("t6_nordy", rdy_cnt, 0);
    rst = 1'b1;
    mcnt = 0;
    mem_lat = 2;
    clr();
    req_execute = 4'b0101;
    wait_exec("t6_exec2", 1, 10);
    chk("t6_grant0", 32'(grants[0]), 0);
    req_execute = '0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
